// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: clearable payload, preserved sideband, valid bit,
// flush, saturating bubble/hold counters and a sticky stall watchdog.
module pipe_stage_reg #(
    parameter int DATA_W   = 128,
    parameter int SIDE_W   = 66,
    parameter int STALL_W  = 6,
    parameter int STAGE    = 2,
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SIDE_W-1:0]  out_side,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               wdog_timeout
);

    logic do_bubble, do_hold, do_load;
    // Only our own and the downstream stall bits matter; the rest are deliberately dropped.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        do_bubble = !flush && stall[STAGE] && !stall[STAGE+1];
        do_hold   = !flush && stall[STAGE] &&  stall[STAGE+1];
        do_load   = !flush && !stall[STAGE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= '0;
        end else if (do_bubble) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (do_load) begin
            out_valid <= in_valid;
            out_data  <= in_valid ? in_data : '0;
            out_side  <= in_side;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (do_bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
            if (do_hold && !(&hold_cnt))     hold_cnt   <= hold_cnt + 1'b1;
        end
    end

    generate
        if (WDOG_CYC > 0) begin : g_wdog
            localparam int RUN_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC + 1) : 1;
            logic [RUN_W-1:0] run, run_inc;

            // Run length parks at the limit so a very long hold never wraps back under it.
            assign run_inc = (run == RUN_W'(WDOG_CYC)) ? run : run + 1'b1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    run          <= '0;
                    wdog_timeout <= 1'b0;
                end else begin
                    run <= do_hold ? run_inc : '0;
                    if (flush || cnt_clr)
                        wdog_timeout <= 1'b0;
                    else if (do_hold && run_inc == RUN_W'(WDOG_CYC))
                        wdog_timeout <= 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign wdog_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, corner-case sequences and a random
// phase, all cross-checked against a behavioural model through an expectation queue.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32, SIDE_W = 8, STALL_W = 6, STAGE = 2, CNT_W = 4, WDOG_CYC = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [STALL_W-1:0] stall = '0;
    logic               flush = 1'b0, cnt_clr = 1'b0, in_valid = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic [SIDE_W-1:0]  in_side = '0;
    logic               out_valid, wdog_timeout;
    logic [DATA_W-1:0]  out_data;
    logic [SIDE_W-1:0]  out_side;
    logic [CNT_W-1:0]   bubble_cnt, hold_cnt;

    pipe_stage_reg #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .STALL_W(STALL_W), .STAGE(STAGE),
                     .CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_data(in_data), .in_side(in_side),
        .out_valid(out_valid), .out_data(out_data), .out_side(out_side),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .wdog_timeout(wdog_timeout));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush, clr, iv;
        logic [31:0] d;
        logic [7:0]  s;
    } vec_t;

    typedef struct {
        logic        ov;
        logic [31:0] od;
        logic [7:0]  os;
        logic [3:0]  bc, hc;
        logic        wd;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    int checks = 0, errors = 0;
    exp_t m;
    int   m_run;
    exp_t q[$];
    rec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(out_valid), 32'(e.ov));
        chk({tag, ".data"},  out_data,        e.od);
        chk({tag, ".side"},  32'(out_side),   32'(e.os));
        chk({tag, ".bcnt"},  32'(bubble_cnt), 32'(e.bc));
        chk({tag, ".hcnt"},  32'(hold_cnt),   32'(e.hc));
        chk({tag, ".wdog"},  32'(wdog_timeout), 32'(e.wd));
    endtask

    task automatic model_reset();
        m = '{default: '0};
        m_run = 0;
        q.delete();
    endtask

    // Reference behaviour of one clock edge, written from the action table.
    task automatic model_step(input vec_t v);
        logic s0, s1, hold_c, bub_c;
        s0 = v.stall[STAGE];
        s1 = v.stall[STAGE+1];
        hold_c = !v.flush && s0 && s1;
        bub_c  = !v.flush && s0 && !s1;
        if (v.flush) begin
            m.ov = 0; m.od = 0; m.os = 0;
        end else if (bub_c) begin
            m.ov = 0; m.od = 0;
        end else if (!s0) begin
            m.ov = v.iv; m.od = v.iv ? v.d : 32'h0; m.os = v.s;
        end
        if (v.clr) begin
            m.bc = 0; m.hc = 0;
        end else begin
            if (bub_c && m.bc != 4'hF) m.bc = m.bc + 1;
            if (hold_c && m.hc != 4'hF) m.hc = m.hc + 1;
        end
        m_run = hold_c ? ((m_run >= WDOG_CYC) ? WDOG_CYC : m_run + 1) : 0;
        if (v.flush || v.clr) m.wd = 0;
        else if (hold_c && m_run == WDOG_CYC) m.wd = 1;
    endtask

    // Called just after a rising edge: apply, predict, let one edge pass, compare.
    task automatic drive(input vec_t v);
        exp_t e;
        stall = v.stall; flush = v.flush; cnt_clr = v.clr;
        in_valid = v.iv; in_data = v.d; in_side = v.s;
        model_step(v);
        q.push_back(m);
        @(posedge clk); #1;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb.empty actual=0 expected=1");
        end else begin
            e = q.pop_front();
            check_all("sb", e);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] st, input logic fl, input logic cl,
                                input logic iv, input logic [31:0] d, input logic [7:0] s);
        vec_t v;
        v.stall = st; v.flush = fl; v.clr = cl; v.iv = iv; v.d = d; v.s = s;
        return v;
    endfunction

    function automatic exp_t ex(input logic ov, input logic [31:0] od, input logic [7:0] os,
                                input logic [3:0] bc, input logic [3:0] hc, input logic wd);
        exp_t e;
        e.ov = ov; e.od = od; e.os = os; e.bc = bc; e.hc = hc; e.wd = wd;
        return e;
    endfunction

    initial begin
        vec_t v;
        exp_t zero_e;
        zero_e = ex(0, 0, 0, 0, 0, 0);

        tbl[0]  = '{mk(6'b000000, 0, 0, 1, 32'hDEADBEEF, 8'hA5), ex(1, 32'hDEADBEEF, 8'hA5, 0, 0, 0)};
        tbl[1]  = '{mk(6'b000000, 0, 0, 0, 32'h12345678, 8'h3C), ex(0, 32'h0, 8'h3C, 0, 0, 0)};
        tbl[2]  = '{mk(6'b000000, 0, 0, 1, 32'hDEADBEEF, 8'hA5), ex(1, 32'hDEADBEEF, 8'hA5, 0, 0, 0)};
        tbl[3]  = '{mk(6'b000100, 0, 0, 1, 32'h11111111, 8'h11), ex(0, 32'h0, 8'hA5, 1, 0, 0)};
        tbl[4]  = '{mk(6'b000000, 0, 0, 1, 32'hCAFEF00D, 8'h5A), ex(1, 32'hCAFEF00D, 8'h5A, 1, 0, 0)};
        tbl[5]  = '{mk(6'b001100, 0, 0, 1, 32'h22222222, 8'h22), ex(1, 32'hCAFEF00D, 8'h5A, 1, 1, 0)};
        tbl[6]  = '{mk(6'b001100, 0, 0, 0, 32'h33333333, 8'h33), ex(1, 32'hCAFEF00D, 8'h5A, 1, 2, 0)};
        tbl[7]  = '{mk(6'b001100, 0, 0, 1, 32'h44444444, 8'h44), ex(1, 32'hCAFEF00D, 8'h5A, 1, 3, 0)};
        tbl[8]  = '{mk(6'b001100, 0, 0, 1, 32'h55555555, 8'h55), ex(1, 32'hCAFEF00D, 8'h5A, 1, 4, 1)};
        tbl[9]  = '{mk(6'b000000, 1, 0, 1, 32'h66666666, 8'h66), ex(0, 32'h0, 8'h00, 1, 4, 0)};
        tbl[10] = '{mk(6'b000100, 1, 0, 1, 32'h77777777, 8'h77), ex(0, 32'h0, 8'h00, 1, 4, 0)};
        tbl[11] = '{mk(6'b110011, 0, 0, 1, 32'h0BADF00D, 8'h77), ex(1, 32'h0BADF00D, 8'h77, 1, 4, 0)};
        tbl[12] = '{mk(6'b001100, 1, 0, 1, 32'h88888888, 8'h88), ex(0, 32'h0, 8'h00, 1, 4, 0)};

        // Power-on reset, including one edge with rst held.
        #1 rst = 1'b1;
        #1 check_all("reset", zero_e);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v);
            check_all($sformatf("vec%0d", i), tbl[i].e);
        end

        // Bubble counter saturation, then clear on a bubble cycle.
        for (int i = 1; i <= 20; i++) begin
            drive(mk(6'b000100, 0, 0, 1, 32'h9, 8'h9));
            chk($sformatf("sat%0d", i), 32'(bubble_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        drive(mk(6'b000100, 0, 1, 1, 32'h9, 8'h9));
        chk("clr.bcnt", 32'(bubble_cnt), 32'd0);
        chk("clr.hcnt", 32'(hold_cnt), 32'd0);

        // cnt_clr also drops a tripped watchdog.
        for (int i = 0; i < 4; i++) drive(mk(6'b001100, 0, 0, 0, 32'h0, 8'h0));
        chk("wd.trip", 32'(wdog_timeout), 32'd1);
        drive(mk(6'b000000, 0, 1, 0, 32'h0, 8'h0));
        chk("wd.clr", 32'(wdog_timeout), 32'd0);

        // Asynchronous reset between edges while holding a valid entry.
        drive(mk(6'b000000, 0, 0, 1, 32'h13579BDF, 8'hC3));
        chk("pre_rst.valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 check_all("async_rst", zero_e);
        v = mk(6'b000000, 0, 0, 1, 32'hFEEDFACE, 8'hEE);
        stall = v.stall; flush = 0; cnt_clr = 0; in_valid = 1; in_data = v.d; in_side = v.s;
        @(posedge clk); #1;
        check_all("rst_hold", zero_e);
        rst = 1'b0;
        model_reset();

        // Reset in the middle of a hold run discards the run length.
        for (int i = 0; i < 3; i++) drive(mk(6'b001100, 0, 0, 0, 32'h0, 8'h0));
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) drive(mk(6'b001100, 0, 0, 0, 32'h0, 8'h0));
        chk("midhold.wd3", 32'(wdog_timeout), 32'd0);
        drive(mk(6'b001100, 0, 0, 0, 32'h0, 8'h0));
        chk("midhold.wd4", 32'(wdog_timeout), 32'd1);

        // Random traffic against the model; clears only land outside hold cycles.
        for (int i = 0; i < 300; i++) begin
            v.stall = 6'($urandom);
            v.stall[STAGE] = ($urandom_range(0, 9) < 6);
            v.flush = ($urandom_range(0, 11) == 0);
            v.clr = !(!v.flush && v.stall[STAGE] && v.stall[STAGE+1]) && ($urandom_range(0, 15) == 0);
            v.iv = 1'($urandom);
            v.d = $urandom;
            v.s = 8'($urandom);
            drive(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
